// File: rtl/rom_pkg.sv
// Shared types and constants for the pipelined instruction ROM reader:
// FSM states, wait counter width, MIPS opcode/funct fields and the ROM image.
package rom_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    localparam int unsigned WAIT_W = 4;

    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] OP_J      = 6'h02;
    localparam logic [5:0] OP_LW     = 6'h23;
    localparam logic [5:0] FUNCT_ADD = 6'h20;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] REG_V0   = 5'd2;

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] funct);
        return {OP_RTYPE, rs, rt, rd, 5'd0, funct};
    endfunction

    function automatic logic [31:0] enc_j(input logic [25:0] target);
        return {OP_J, target};
    endfunction

    localparam int unsigned ROM_LEN   = 9;
    localparam int unsigned ROM_IDX_W = $clog2(ROM_LEN);

    // Element 0 is the rightmost term of the concatenation.
    localparam logic [ROM_LEN-1:0][31:0] ROM_IMAGE = {
        enc_r(REG_V0, REG_V0, REG_V0, FUNCT_ADD),  // 8: add $2,$2,$2
        enc_r(REG_V0, REG_V0, REG_V0, FUNCT_ADD),  // 7: add $2,$2,$2
        32'h0000_0000,                             // 6
        32'h0000_0000,                             // 5
        32'h0000_0000,                             // 4
        enc_r(REG_V0, REG_V0, REG_V0, FUNCT_ADD),  // 3: add $2,$2,$2
        enc_j(26'd7),                              // 2: j 7
        enc_r(REG_V0, REG_V0, REG_V0, FUNCT_ADD),  // 1: add $2,$2,$2
        enc_i(OP_LW, REG_ZERO, REG_V0, 16'd4)      // 0: lw $2,4($0)
    };

    // Word lookup over the full decoded window; slots past the image read 0.
    function automatic logic [31:0] rom_word(input logic [9:0] idx);
        logic [31:0] w;
        w = '0;
        for (int unsigned i = 0; i < ROM_LEN; i++) begin
            if (idx == 10'(i)) begin
                w = ROM_IMAGE[i[ROM_IDX_W-1:0]];
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/rom_addr_decode.sv
// Combinational address decode for the ROM reader: word offset, alignment
// check and window (BASE_ADDR) check on the captured byte address.
module rom_addr_decode #(
    parameter int unsigned             ADDR_W    = 32,
    parameter int unsigned             DEPTH     = 64,
    parameter logic [ADDR_W-1:0]       BASE_ADDR = '0,
    parameter int unsigned             OFF_W     = $clog2(DEPTH)
) (
    input  logic [ADDR_W-1:0] addr,
    output logic [OFF_W-1:0]  offset,
    output logic              unaligned,
    output logic              out_of_window
);

    localparam int unsigned HI_W = ADDR_W - OFF_W - 2;

    logic [HI_W-1:0] base_hi;

    always_comb begin
        base_hi       = BASE_ADDR[HI_W-1:0];
        offset        = addr[OFF_W+1:2];
        unaligned     = |addr[1:0];
        out_of_window = (addr[ADDR_W-1:OFF_W+2] != base_hi);
    end

endmodule

// File: rtl/rom_pipe_reader.sv
// Request/response ROM reader with configurable wait states and error count.
// Optional resp_par output when ROM_PARITY_EN is defined.
module rom_pipe_reader
    import rom_pkg::*;
#(
    parameter int unsigned       ADDR_W      = 32,
    parameter int unsigned       DATA_W      = 32,
    parameter int unsigned       DEPTH       = 64,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
    parameter int unsigned       WAIT_STATES = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic              resp_err,
    output logic [7:0]        err_cnt
`ifdef ROM_PARITY_EN
    ,
    output logic              resp_par
`endif
);

    localparam int unsigned OFF_W = $clog2(DEPTH);

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [ADDR_W-1:0] addr_q;
    logic              run_q;
    logic              accept;
    logic              resp_hs;
    logic [OFF_W-1:0]  offset;
    logic              unaligned;
    logic              out_of_window;

    rom_addr_decode #(
        .ADDR_W    (ADDR_W),
        .DEPTH     (DEPTH),
        .BASE_ADDR (BASE_ADDR),
        .OFF_W     (OFF_W)
    ) u_decode (
        .addr          (addr_q),
        .offset        (offset),
        .unaligned     (unaligned),
        .out_of_window (out_of_window)
    );

    // run_q holds req_ready low for the cycle(s) reset is asserted.
    always_comb begin
        req_ready  = run_q && (state_q == ST_IDLE);
        accept     = req_valid && req_ready;
        resp_valid = (state_q == ST_RESP);
        resp_hs    = resp_valid && resp_ready;
        resp_err   = resp_valid && (unaligned || out_of_window);
        if (resp_valid && !resp_err) begin
            resp_data = DATA_W'(rom_word(10'(offset)));
        end else begin
            resp_data = '0;
        end
    end

`ifdef ROM_PARITY_EN
    assign resp_par = ^resp_data;
`endif

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (WAIT_STATES > 0) begin
                        state_d = ST_WAIT;
                        wait_d  = WAIT_W'(WAIT_STATES - 1);
                    end else begin
                        state_d = ST_RESP;
                    end
                end
            end
            ST_WAIT: begin
                if (wait_q == '0) begin
                    state_d = ST_RESP;
                end else begin
                    wait_d = wait_q - WAIT_W'(1);
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            wait_q  <= '0;
            addr_q  <= '0;
            run_q   <= 1'b0;
            err_cnt <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            run_q   <= 1'b1;
            if (accept) begin
                addr_q <= req_addr;
            end
            if (resp_hs && resp_err && (err_cnt != 8'hFF)) begin
                err_cnt <= err_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_rom_pipe_reader.sv
// Directed self-checking bench: three readers (0, 3 and 5 wait states)
// sharing reset and address, each with its own valid/ready handshakes.
module tb_rom_pipe_reader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic [31:0] req_addr;
    logic        rv0, rv3, rv5, rr0, rr3, rr5;
    logic        rdy0, rdy3, rdy5, vld0, vld3, vld5, err0, err3, err5;
    logic [31:0] data0, data3, data5;
    logic [7:0]  cnt0, cnt3, cnt5;
`ifdef ROM_PARITY_EN
    logic        par0, par3, par5;
`endif

    int total = 0;
    int bad   = 0;

    rom_pipe_reader #(.WAIT_STATES(0)) d0 (
        .clk(clk), .reset_n(reset_n), .req_valid(rv0), .req_ready(rdy0),
        .req_addr(req_addr), .resp_valid(vld0), .resp_ready(rr0),
        .resp_data(data0), .resp_err(err0), .err_cnt(cnt0)
`ifdef ROM_PARITY_EN
        , .resp_par(par0)
`endif
    );

    rom_pipe_reader #(.WAIT_STATES(3)) d3 (
        .clk(clk), .reset_n(reset_n), .req_valid(rv3), .req_ready(rdy3),
        .req_addr(req_addr), .resp_valid(vld3), .resp_ready(rr3),
        .resp_data(data3), .resp_err(err3), .err_cnt(cnt3)
`ifdef ROM_PARITY_EN
        , .resp_par(par3)
`endif
    );

    rom_pipe_reader #(.WAIT_STATES(5)) d5 (
        .clk(clk), .reset_n(reset_n), .req_valid(rv5), .req_ready(rdy5),
        .req_addr(req_addr), .resp_valid(vld5), .resp_ready(rr5),
        .resp_data(data5), .resp_err(err5), .err_cnt(cnt5)
`ifdef ROM_PARITY_EN
        , .resp_par(par5)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request on d0 and wait (bounded) for its response.
    task automatic req_d0(input logic [31:0] a, output int n);
        req_addr = a;
        rv0 = 1'b1;
        n = 0;
        do begin
            tick();
            rv0 = 1'b0;
            n++;
        end while (!vld0 && n < 20);
    endtask

    task automatic hs_d0();
        rr0 = 1'b1;
        tick();
        rr0 = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        logic        seen;
        logic [31:0] w;
        logic [31:0] taddr [4] = '{32'h08, 32'h20, 32'h24, 32'hFC};
        logic [31:0] tdata [4] = '{32'h0800_0007, 32'h0042_1020, 32'h0, 32'h0};

        reset_n = 1'b0; req_addr = '0;
        rv0 = 0; rv3 = 0; rv5 = 0; rr0 = 0; rr3 = 0; rr5 = 0;
        repeat (3) tick();
        chk("rst_ready", rdy0, 0);
        chk("rst_valid", vld0, 0);
        chk("rst_data", data0, 0);
        chk("rst_err", err0, 0);
        chk("rst_cnt", cnt0, 0);

        reset_n = 1'b1;
        chk("ready_before_edge", rdy0, 0);
        tick();
        chk("ready_first_edge", rdy0, 1);
        chk("ready_first_edge_d3", rdy3, 1);

        // zero wait states, word 0
        req_d0(32'h00, n);
        chk("ws0_latency", n, 1);
        chk("ws0_data", data0, 32'h8C02_0004);
        chk("ws0_err", err0, 0);
        chk("ws0_ready_busy", rdy0, 0);
        hs_d0();
        chk("ws0_valid_after_hs", vld0, 0);
        chk("ws0_ready_after_hs", rdy0, 1);

        // three wait states, word 1
        req_addr = 32'h04; rv3 = 1'b1; n = 0;
        do begin
            tick();
            rv3 = 1'b0;
            n++;
            if (n == 2) chk("ws3_ready_in_wait", rdy3, 0);
        end while (!vld3 && n < 20);
        chk("ws3_latency", n, 4);
        chk("ws3_data", data3, 32'h0042_1020);
        chk("ws3_err", err3, 0);
        rr3 = 1'b1; tick(); rr3 = 1'b0;
        chk("ws3_valid_after_hs", vld3, 0);

        // unaligned and out-of-window errors
        req_d0(32'h06, n);
        chk("unal_err", err0, 1);
        chk("unal_data", data0, 0);
        hs_d0();
        chk("unal_cnt", cnt0, 1);
        req_d0(32'h100, n);
        chk("win_err", err0, 1);
        chk("win_data", data0, 0);
        hs_d0();
        chk("win_cnt", cnt0, 2);

        // image contents, past-image slot and last slot in window
        for (int i = 0; i < 4; i++) begin
            req_d0(taddr[i], n);
            chk($sformatf("rd_lat_%0h", taddr[i]), n, 1);
            chk($sformatf("rd_data_%0h", taddr[i]), data0, tdata[i]);
            chk($sformatf("rd_err_%0h", taddr[i]), err0, 0);
            hs_d0();
        end
        chk("rd_cnt_unchanged", cnt0, 2);

        // resp_ready while idle is ignored
        rr0 = 1'b1; tick(); tick(); rr0 = 1'b0;
        chk("idle_rr_valid", vld0, 0);
        chk("idle_rr_cnt", cnt0, 2);
        chk("idle_rr_ready", rdy0, 1);

        // backpressure with changing address and a pending request
        req_d0(32'h1C, n);
        rv0 = 1'b1;
        for (int k = 0; k < 5; k++) begin
            req_addr = (k % 2 == 0) ? 32'h06 : 32'h100;
            tick();
            chk($sformatf("hold_valid_%0d", k), vld0, 1);
            chk($sformatf("hold_data_%0d", k), data0, 32'h0042_1020);
            chk($sformatf("hold_err_%0d", k), err0, 0);
            chk($sformatf("hold_ready_%0d", k), rdy0, 0);
        end
        rv0 = 1'b0;
        hs_d0();
        chk("hold_valid_after_hs", vld0, 0);
        tick();
        chk("hold_single_hs", vld0, 0);
        chk("hold_cnt", cnt0, 2);

        // reset during WAIT on the five-wait-state reader
        req_addr = 32'h06; rv5 = 1'b1;
        tick();
        rv5 = 1'b0;
        tick(); tick();
        chk("ws5_ready_in_wait", rdy5, 0);
        chk("ws5_valid_in_wait", vld5, 0);
        reset_n = 1'b0;
        tick();
        chk("midrst_valid", vld5, 0);
        chk("midrst_ready", rdy5, 0);
        chk("midrst_cnt_clear", cnt0, 0);
        reset_n = 1'b1;
        tick();
        chk("midrst_ready_release", rdy5, 1);
        seen = 1'b0;
        repeat (8) begin
            tick();
            if (vld5) seen = 1'b1;
        end
        chk("midrst_no_pulse", seen, 0);
        chk("midrst_cnt5", cnt5, 0);

        // saturation of the error counter
        for (int i = 0; i < 260; i++) begin
            req_addr = 32'h06; rv0 = 1'b1;
            tick();
            rv0 = 1'b0; rr0 = 1'b1;
            tick();
            rr0 = 1'b0;
            if (i == 253) chk("sat_cnt_254", cnt0, 254);
        end
        chk("sat_cnt_255", cnt0, 255);

`ifdef ROM_PARITY_EN
        chk("par_idle", par0, 0);
        req_d0(32'h04, n);
        w = 32'h0042_1020;
        chk("par_word1", par0, ^w);
        hs_d0();
        req_d0(32'h08, n);
        w = 32'h0800_0007;
        chk("par_word2", par0, ^w);
        hs_d0();
        req_d0(32'h00, n);
        w = 32'h8C02_0004;
        chk("par_word0", par0, ^w);
        hs_d0();
`else
        w = '0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
